// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed BCD, one shift per clock.
// Optional macro BCD_BLANK_EN enables registered leading-zero blank flags.
module bin_to_bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic [D-1:0]   blank
);
  localparam int SW = W + 4*D;
  localparam int CW = $clog2(W+1);
  localparam longint MAXV = (longint'(1) << W) - 1;
  localparam longint P10 = longint'(10) ** D;
  if (P10 <= MAXV) begin : g_bad_d
    $error("bin_to_bcd_seq: D too small for W");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [SW-1:0] sr, corr, nxt;
  logic [CW-1:0] cnt;
  assign busy = (state == SHIFT);
  always_comb begin
    corr = sr;
    for (int i = 0; i < D; i++)
      corr[W+4*i +: 4] = sr[W+4*i +: 4] >= 4'd5 ? sr[W+4*i +: 4] + 4'd3 : sr[W+4*i +: 4];
  end
  assign nxt = corr << 1;
`ifdef BCD_BLANK_EN
  logic [D-1:0] blank_nxt;
  logic z;
  always_comb begin
    blank_nxt = '0;
    z = 1'b1;
    for (int i = D-1; i >= 1; i--) begin
      z = z & (nxt[W+4*i +: 4] == 4'd0);
      blank_nxt[i] = z;
    end
  end
`else
  assign blank = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      bcd   <= '0;
`ifdef BCD_BLANK_EN
      blank <= ~D'(1);
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sr    <= {{(4*D){1'b0}}, bin};
          cnt   <= CW'(W);
          state <= SHIFT;
        end
      end else begin
        sr  <= nxt;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd   <= nxt[SW-1 -: 4*D];
          done  <= 1'b1;
          state <= IDLE;
`ifdef BCD_BLANK_EN
          blank <= blank_nxt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and randomized checks of bin_to_bcd_seq against a decimal model.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic reset, start;
  logic [7:0] bin;
  logic busy, done;
  logic [11:0] bcd;
  logic [2:0] blank;
  int checks = 0, errors = 0;

  bin_to_bcd_seq #(.W(8), .D(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd_of(int v);
    return 12'(((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
  endfunction

  function automatic logic [2:0] blank_of(int v);
`ifdef BCD_BLANK_EN
    return {v < 100, v < 10, 1'b0};
`else
    return 3'b000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(int v);
    start = 1'b1;
    bin = 8'(v);
    tick();
    start = 1'b0;
    bin = 8'($urandom);
    chk("go_busy", 32'(busy), 1);
    chk("go_done", 32'(done), 0);
  endtask

  task automatic wait_done(int exp_lat, int v);
    int lat = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat = i + 1;
      if (done) break;
      chk("busy_mid", 32'(busy), 1);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("bcd", 32'(bcd), 32'(bcd_of(v)));
    chk("blank", 32'(blank), 32'(blank_of(v)));
    chk("busy_at_done", 32'(busy), 0);
  endtask

  task automatic no_done(string tag, int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen++;
    end
    chk(tag, 32'(seen), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd), 0);
`ifdef BCD_BLANK_EN
    chk("rst_blank", 32'(blank), 32'b110);
`else
    chk("rst_blank", 32'(blank), 32'b000);
`endif
    go(255);
    wait_done(8, 255);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    go(9);
    wait_done(8, 9);
    go(0);
    wait_done(8, 0);
    tick();
    go(100);
    tick();
    tick();
    start = 1'b1;
    bin = 8'd7;
    tick();
    start = 1'b0;
    wait_done(5, 100);
    no_done("no_second_done", 12);
    chk("bcd_hold", 32'(bcd), 32'h100);
    go(200);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd), 0);
    no_done("abort_no_done", 12);
    go(42);
    wait_done(8, 42);
    tick();
    reset = 1'b1;
    start = 1'b1;
    bin = 8'd77;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 0);
    tick();
    chk("rst_start_busy2", 32'(busy), 0);
    for (int v = 0; v < 256; v++) begin
      go(v);
      wait_done(8, v);
    end
    for (int n = 0; n < 20; n++) begin
      int v = int'($urandom_range(0, 255));
      go(v);
      wait_done(8, v);
      if ($urandom_range(0, 1) == 1) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
